// File: rtl/pic_multichannel_pkg.sv
// Shared definitions for the multichannel interrupt controller: register map,
// CONTROL/EOI bit positions, handshake states and the priority resolver result.
package pic_multichannel_pkg;
  localparam int ID_W = 5;

  localparam logic [2:0] ADDR_CONTROL  = 3'd0;
  localparam logic [2:0] ADDR_MASK     = 3'd1;
  localparam logic [2:0] ADDR_TRIGGER  = 3'd2;
  localparam logic [2:0] ADDR_EOI      = 3'd3;
  localparam logic [2:0] ADDR_IRR      = 3'd4;
  localparam logic [2:0] ADDR_ISR      = 3'd5;
  localparam logic [2:0] ADDR_PRIORITY = 3'd6;

  localparam int CTRL_AUTO_EOI    = 0;
  localparam int CTRL_ROTATE      = 1;
  localparam int CTRL_VBASE_LSB   = 8;
  localparam int CTRL_VBASE_MSB   = 15;
  localparam int EOI_SPECIFIC_BIT = 8;

  typedef enum logic [1:0] {IDLE, PENDING, ACK} pic_state_e;

  typedef struct packed {
    logic            win_vld;
    logic [ID_W-1:0] win_id;
    logic            isr_any;
    logic [ID_W-1:0] isr_top;
  } pic_resolve_t;
endpackage

// File: rtl/pic_multichannel_controller_if.sv
// Register bus plus CPU/peripheral interrupt signals of the controller.
interface pic_multichannel_controller_if #(
  parameter int NUM_IRQ      = 16,
  parameter int VECTOR_WIDTH = 8
);
  logic                    register_write;
  logic                    register_read;
  logic [2:0]              register_address;
  logic [31:0]             register_write_data;
  logic [31:0]             register_read_data;
  logic [NUM_IRQ-1:0]      interrupt_request;
  logic                    interrupt_to_cpu;
  logic                    interrupt_acknowledge;
  logic [VECTOR_WIDTH-1:0] interrupt_vector;
  logic                    interrupt_vector_valid;

  modport master (
    output register_write, register_read, register_address, register_write_data,
           interrupt_request, interrupt_acknowledge,
    input  register_read_data, interrupt_to_cpu, interrupt_vector, interrupt_vector_valid
  );

  modport slave (
    input  register_write, register_read, register_address, register_write_data,
           interrupt_request, interrupt_acknowledge,
    output register_read_data, interrupt_to_cpu, interrupt_vector, interrupt_vector_valid
  );
endinterface

// File: rtl/pic_priority_resolver.sv
// Combinational arbiter: rotate so the highest-priority channel sits at bit 0,
// find-first on requests and in-service bits, then rotate the ids back.
module pic_priority_resolver
  import pic_multichannel_pkg::*;
#(
  parameter int NUM_IRQ = 16
) (
  input  logic [NUM_IRQ-1:0] request,
  input  logic [NUM_IRQ-1:0] mask,
  input  logic [NUM_IRQ-1:0] isr,
  input  logic [ID_W-1:0]    lowest_priority,
  output pic_resolve_t       result
);
  logic [ID_W:0]        base, req_pos, isr_pos, req_id, isr_id;
  logic [2*NUM_IRQ-1:0] req_sh, isr_sh;
  logic [NUM_IRQ-1:0]   req_rot, isr_rot;
  logic                 req_any, isr_any;

  always_comb begin
    base    = (lowest_priority >= ID_W'(NUM_IRQ-1)) ? '0 : {1'b0, lowest_priority} + 6'd1;
    req_sh  = {request & ~mask, request & ~mask} >> base;
    isr_sh  = {isr, isr} >> base;
    req_rot = req_sh[NUM_IRQ-1:0];
    isr_rot = isr_sh[NUM_IRQ-1:0];
    req_any = 1'b0;
    isr_any = 1'b0;
    req_pos = '0;
    isr_pos = '0;
    // Descending scan so the lowest rotated position (highest priority) wins.
    for (int k = NUM_IRQ-1; k >= 0; k--) begin
      if (req_rot[k]) begin req_any = 1'b1; req_pos = 6'(k); end
      if (isr_rot[k]) begin isr_any = 1'b1; isr_pos = 6'(k); end
    end
    req_id = req_pos + base;
    if (req_id >= 6'(NUM_IRQ)) req_id = req_id - 6'(NUM_IRQ);
    isr_id = isr_pos + base;
    if (isr_id >= 6'(NUM_IRQ)) isr_id = isr_id - 6'(NUM_IRQ);
    result.win_vld = req_any && (!isr_any || req_pos < isr_pos);
    result.win_id  = req_id[ID_W-1:0];
    result.isr_any = isr_any;
    result.isr_top = isr_id[ID_W-1:0];
  end
endmodule

// File: rtl/pic_multichannel_controller.sv
// Interrupt controller top: config registers, IRR/ISR tracking with edge detect,
// acknowledge handshake FSM and registered read mux.
module pic_multichannel_controller
  import pic_multichannel_pkg::*;
#(
  parameter int NUM_IRQ      = 16,
  parameter int VECTOR_WIDTH = 8
) (
  input  logic                          clock,
  input  logic                          reset_n,
  pic_multichannel_controller_if.slave  bus
);
  localparam logic [NUM_IRQ-1:0] ONE = {{(NUM_IRQ-1){1'b0}}, 1'b1};

  logic                    auto_eoi, rotate_on_eoi;
  logic [7:0]              vector_base;
  logic [NUM_IRQ-1:0]      mask_q, trigger_q, irr_q, isr_q, pin_q;
  logic [ID_W-1:0]         lowest_q, lowest_nxt;
  logic [NUM_IRQ-1:0]      win_bit, rise, isr_nxt, irr_nxt;
  logic                    ack_take, eoi_wr;
  logic [VECTOR_WIDTH-1:0] vec_base_w, win_vec, spur_vec;
  pic_state_e              state;
  pic_resolve_t            res;

  pic_priority_resolver #(.NUM_IRQ(NUM_IRQ)) u_resolver (
    .request(irr_q), .mask(mask_q), .isr(isr_q), .lowest_priority(lowest_q), .result(res)
  );

  assign eoi_wr     = bus.register_write && bus.register_address == ADDR_EOI;
  assign ack_take   = bus.interrupt_acknowledge && state == PENDING && res.win_vld;
  assign win_bit    = ONE << res.win_id;
  assign rise       = bus.interrupt_request & ~pin_q;
  assign vec_base_w = VECTOR_WIDTH'(vector_base);
  assign win_vec    = vec_base_w + VECTOR_WIDTH'(res.win_id);
  assign spur_vec   = vec_base_w + VECTOR_WIDTH'(NUM_IRQ-1);

  // EOI is applied before the acknowledge sets its ISR bit in the same cycle.
  always_comb begin
    isr_nxt    = isr_q;
    lowest_nxt = lowest_q;
    if (eoi_wr) begin
      if (bus.register_write_data[EOI_SPECIFIC_BIT]) begin
        isr_nxt = isr_q & ~(ONE << bus.register_write_data[4:0]);
      end else if (res.isr_any) begin
        isr_nxt = isr_q & ~(ONE << res.isr_top);
        if (rotate_on_eoi) lowest_nxt = res.isr_top;
      end
    end
    if (ack_take && !auto_eoi) isr_nxt = isr_nxt | win_bit;
    if (ack_take && auto_eoi && rotate_on_eoi) lowest_nxt = res.win_id;
    irr_nxt = (trigger_q & ((irr_q & ~(ack_take ? win_bit : '0)) | rise))
            | (~trigger_q & bus.interrupt_request);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      auto_eoi      <= 1'b0;
      rotate_on_eoi <= 1'b0;
      vector_base   <= '0;
      mask_q        <= '1;
      trigger_q     <= '1;
      irr_q         <= '0;
      isr_q         <= '0;
      pin_q         <= '0;
      lowest_q      <= ID_W'(NUM_IRQ-1);
    end else begin
      irr_q    <= irr_nxt;
      isr_q    <= isr_nxt;
      lowest_q <= lowest_nxt;
      pin_q    <= bus.interrupt_request;
      if (bus.register_write) begin
        case (bus.register_address)
          ADDR_CONTROL: begin
            auto_eoi      <= bus.register_write_data[CTRL_AUTO_EOI];
            rotate_on_eoi <= bus.register_write_data[CTRL_ROTATE];
            vector_base   <= bus.register_write_data[CTRL_VBASE_MSB:CTRL_VBASE_LSB];
          end
          ADDR_MASK:    mask_q    <= bus.register_write_data[NUM_IRQ-1:0];
          ADDR_TRIGGER: trigger_q <= bus.register_write_data[NUM_IRQ-1:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.register_read_data <= '0;
    end else if (bus.register_read) begin
      case (bus.register_address)
        ADDR_CONTROL:  bus.register_read_data <= {16'h0, vector_base, 6'h0, rotate_on_eoi, auto_eoi};
        ADDR_MASK:     bus.register_read_data <= 32'(mask_q);
        ADDR_TRIGGER:  bus.register_read_data <= 32'(trigger_q);
        ADDR_IRR:      bus.register_read_data <= 32'(irr_q);
        ADDR_ISR:      bus.register_read_data <= 32'(isr_q);
        ADDR_PRIORITY: bus.register_read_data <= 32'(lowest_q);
        default:       bus.register_read_data <= '0;
      endcase
    end
  end

  // Acknowledge outside PENDING, or with no winner left, returns the spurious vector.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state                      <= IDLE;
      bus.interrupt_to_cpu       <= 1'b0;
      bus.interrupt_vector       <= '0;
      bus.interrupt_vector_valid <= 1'b0;
    end else begin
      bus.interrupt_vector_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.interrupt_acknowledge) begin
            bus.interrupt_vector       <= spur_vec;
            bus.interrupt_vector_valid <= 1'b1;
            state                      <= ACK;
          end else if (res.win_vld) begin
            bus.interrupt_to_cpu <= 1'b1;
            state                <= PENDING;
          end
        end
        PENDING: begin
          if (bus.interrupt_acknowledge) begin
            bus.interrupt_vector       <= res.win_vld ? win_vec : spur_vec;
            bus.interrupt_vector_valid <= 1'b1;
            bus.interrupt_to_cpu       <= 1'b0;
            state                      <= ACK;
          end else if (!res.win_vld) begin
            bus.interrupt_to_cpu <= 1'b0;
            state                <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pic_multichannel_controller.sv
// Directed bench for pic_multichannel_controller with a rank-based behavioural
// model compared every cycle, plus literal expectations from the test plan.
module tb_pic_multichannel_controller;
  localparam int N = 16;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  pic_multichannel_controller_if #(.NUM_IRQ(N), .VECTOR_WIDTH(8)) bus ();
  pic_multichannel_controller #(.NUM_IRQ(N), .VECTOR_WIDTH(8)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [N-1:0] m_mask, m_trig, m_irr, m_isr, m_prev, n_isr, n_irr;
  logic [7:0]   m_base, m_vec;
  logic [31:0]  m_rdata, d;
  logic         m_auto, m_rot, m_int, m_valid, taken;
  int           m_low, m_phase, n_low, w, top;

  // rank 0 = highest priority, given the lowest-priority channel m_low
  function automatic int rank_of(int ch);
    return (ch - m_low - 1 + 2*N) % N;
  endfunction

  function automatic int isr_top();
    int best = -1;
    for (int ch = 0; ch < N; ch++)
      if (m_isr[ch] && (best < 0 || rank_of(ch) < rank_of(best))) best = ch;
    return best;
  endfunction

  function automatic int winner();
    int best = -1;
    int ceil_r = N;
    int t = isr_top();
    if (t >= 0) ceil_r = rank_of(t);
    for (int ch = 0; ch < N; ch++)
      if (m_irr[ch] && !m_mask[ch] && rank_of(ch) < ceil_r &&
          (best < 0 || rank_of(ch) < rank_of(best))) best = ch;
    return best;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_mask = '1; m_trig = '1; m_irr = '0; m_isr = '0; m_prev = '0;
      m_low = N-1; m_auto = 0; m_rot = 0; m_base = 0;
      m_int = 0; m_valid = 0; m_vec = 0; m_rdata = 0; m_phase = 0;
    end else begin
      w = winner();
      top = isr_top();
      d = bus.register_write_data;
      taken = bus.interrupt_acknowledge && m_phase == 1 && w >= 0;
      n_isr = m_isr;
      n_low = m_low;
      if (bus.register_write && bus.register_address == 3'd3) begin
        if (d[8]) begin
          for (int ch = 0; ch < N; ch++) if (ch == int'(d[4:0])) n_isr[ch] = 1'b0;
        end else if (top >= 0) begin
          n_isr[top] = 1'b0;
          if (m_rot) n_low = top;
        end
      end
      if (taken) begin
        if (!m_auto) n_isr[w] = 1'b1;
        else if (m_rot) n_low = w;
      end
      for (int ch = 0; ch < N; ch++)
        if (m_trig[ch])
          n_irr[ch] = (m_irr[ch] && !(taken && w == ch)) ||
                      (bus.interrupt_request[ch] && !m_prev[ch]);
        else
          n_irr[ch] = bus.interrupt_request[ch];
      if (bus.register_read)
        case (bus.register_address)
          3'd0: m_rdata = {16'h0, m_base, 6'h0, m_rot, m_auto};
          3'd1: m_rdata = 32'(m_mask);
          3'd2: m_rdata = 32'(m_trig);
          3'd4: m_rdata = 32'(m_irr);
          3'd5: m_rdata = 32'(m_isr);
          3'd6: m_rdata = 32'(m_low);
          default: m_rdata = 0;
        endcase
      m_valid = 0;
      if (bus.interrupt_acknowledge && m_phase != 2) begin
        m_valid = 1;
        m_vec = m_base + (taken ? 8'(w) : 8'(N-1));
        m_int = 0;
        m_phase = 2;
      end else if (m_phase == 2) m_phase = 0;
      else if (m_phase == 0 && w >= 0) begin m_phase = 1; m_int = 1; end
      else if (m_phase == 1 && w < 0) begin m_phase = 0; m_int = 0; end
      if (bus.register_write)
        case (bus.register_address)
          3'd0: begin m_auto = d[0]; m_rot = d[1]; m_base = d[15:8]; end
          3'd1: m_mask = d[N-1:0];
          3'd2: m_trig = d[N-1:0];
          default: ;
        endcase
      m_isr = n_isr; m_irr = n_irr; m_low = n_low;
      m_prev = bus.interrupt_request;
    end
  end

  always @(negedge clock) begin
    check("int_to_cpu", 32'(bus.interrupt_to_cpu), 32'(m_int));
    check("vector_valid", 32'(bus.interrupt_vector_valid), 32'(m_valid));
    check("vector", 32'(bus.interrupt_vector), 32'(m_vec));
    check("read_data", bus.register_read_data, m_rdata);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] v);
    bus.register_write = 1; bus.register_address = a; bus.register_write_data = v;
    tick();
    bus.register_write = 0;
  endtask

  task automatic rd(input string name, input logic [2:0] a, input logic [31:0] exp);
    bus.register_read = 1; bus.register_address = a;
    tick();
    bus.register_read = 0;
    check(name, bus.register_read_data, exp);
  endtask

  task automatic pulse(input logic [N-1:0] v);
    bus.interrupt_request = v;
    tick();
    bus.interrupt_request = '0;
  endtask

  task automatic wait_int(input string name);
    for (int i = 0; i < 10 && !bus.interrupt_to_cpu; i++) tick();
    check(name, 32'(bus.interrupt_to_cpu), 32'd1);
  endtask

  task automatic ack(input string name, input logic [7:0] exp);
    bus.interrupt_acknowledge = 1;
    tick();
    bus.interrupt_acknowledge = 0;
    check({name, "_valid"}, 32'(bus.interrupt_vector_valid), 32'd1);
    check(name, 32'(bus.interrupt_vector), 32'(exp));
    check({name, "_int_low"}, 32'(bus.interrupt_to_cpu), 32'd0);
  endtask

  initial begin
    bus.register_write = 0; bus.register_read = 0; bus.register_address = 0;
    bus.register_write_data = 0; bus.interrupt_request = 0; bus.interrupt_acknowledge = 0;
    repeat (3) tick();
    reset_n = 1;
    check("rst_int", 32'(bus.interrupt_to_cpu), 0);
    check("rst_vector", 32'(bus.interrupt_vector), 0);
    rd("rst_mask", 3'd1, 32'hFFFF);
    rd("rst_prio", 3'd6, 32'd15);

    // single edge channel, fully nested: stays quiet until EOI
    wr(3'd1, 32'hFFF7);
    pulse(16'h0008);
    wait_int("t1_int");
    ack("t1_vec", 8'h03);
    rd("t1_isr", 3'd5, 32'h0008);
    rd("t1_irr", 3'd4, 32'h0000);
    check("t1_int_quiet", 32'(bus.interrupt_to_cpu), 0);
    wr(3'd3, 32'h0);
    rd("t1_isr_eoi", 3'd5, 32'h0);

    // vector base, simultaneous edges, nesting
    wr(3'd0, 32'h2000);
    wr(3'd1, 32'h0000);
    pulse(16'h0024);
    wait_int("t2_int_a");
    ack("t2_vec_a", 8'h22);
    wr(3'd3, 32'h0);
    wait_int("t2_int_b");
    ack("t2_vec_b", 8'h25);
    pulse(16'h0002);
    wait_int("t2_nest_irq1");
    ack("t2_vec_1", 8'h21);
    wr(3'd3, 32'h0);
    rd("t2_isr5", 3'd5, 32'h0020);
    pulse(16'h0080);
    repeat (3) tick();
    check("t2_irq7_blocked", 32'(bus.interrupt_to_cpu), 0);
    wr(3'd3, 32'h0);
    wait_int("t2_int_7");
    ack("t2_vec_7", 8'h27);
    wr(3'd3, 32'h107);
    rd("t2_isr_clear", 3'd5, 32'h0);

    // level channel 4, then drop while pending, then spurious acknowledge
    wr(3'd2, 32'hFFEF);
    bus.interrupt_request = 16'h0010;
    wait_int("t3_int");
    ack("t3_vec", 8'h24);
    rd("t3_isr", 3'd5, 32'h0010);
    wr(3'd3, 32'h0);
    wait_int("t3_reint");
    bus.interrupt_request = '0;
    repeat (3) tick();
    check("t3_drop", 32'(bus.interrupt_to_cpu), 0);
    ack("t3_spurious", 8'h2F);
    rd("t3_isr_same", 3'd5, 32'h0);
    wr(3'd2, 32'hFFFF);

    // rotate on EOI
    wr(3'd0, 32'h2002);
    pulse(16'h0001);
    wait_int("t4_int0");
    ack("t4_vec0", 8'h20);
    wr(3'd3, 32'h0);
    rd("t4_prio0", 3'd6, 32'd0);
    pulse(16'h0003);
    wait_int("t4_int01");
    ack("t4_vec1", 8'h21);
    wr(3'd3, 32'h0);
    rd("t4_prio1", 3'd6, 32'd1);
    wait_int("t4_int0b");
    ack("t4_vec0b", 8'h20);
    wr(3'd3, 32'h0);

    // auto-EOI
    wr(3'd0, 32'h2001);
    pulse(16'h0040);
    wait_int("t5_int");
    ack("t5_vec", 8'h26);
    rd("t5_isr", 3'd5, 32'h0);
    pulse(16'h0040);
    wait_int("t5_int_again");
    ack("t5_vec_again", 8'h26);

    // reset during the acknowledge cycle aborts the handshake
    pulse(16'h0008);
    wait_int("t6_int");
    bus.interrupt_acknowledge = 1;
    reset_n = 0;
    tick();
    bus.interrupt_acknowledge = 0;
    check("t6_no_valid", 32'(bus.interrupt_vector_valid), 0);
    check("t6_int", 32'(bus.interrupt_to_cpu), 0);
    check("t6_vector", 32'(bus.interrupt_vector), 0);
    check("t6_rdata", bus.register_read_data, 0);
    tick();
    reset_n = 1;
    rd("t6_mask", 3'd1, 32'hFFFF);
    rd("t6_ctrl", 3'd0, 32'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pic_multichannel_controller.md
# pic_multichannel_controller

Clocked, parametrised successor of the 8259A-style interrupt controller. It supports:
- NUM_IRQ request channels, each with its own level or edge trigger select.
- Fully nested priority with rotation.
- Auto-EOI and specific or non-specific EOI.
- A single-pulse acknowledge handshake that returns a vector.

It sits between peripheral interrupt lines and the CPU's interrupt input. Its register port is a simple synchronous read/write bus, not the tri-state 8-bit bus of the legacy block.

## Interface
- NUM_IRQ, 16, number of request channels (2..32)
- VECTOR_WIDTH, 8, width of returned vector
- clock  in  1  single clock; all logic is on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- register_write  in  1  write strobe, one cycle
- register_read  in  1  read strobe, one cycle
- register_address  in  3  register select
- register_write_data  in  32  write data
- register_read_data  out  32  read data, registered, valid the cycle after register_read
- interrupt_request  in  NUM_IRQ  request pins, synchronous to clock
- interrupt_to_cpu  out  1  interrupt pending to CPU
- interrupt_acknowledge  in  1  one-cycle acknowledge pulse from CPU
- interrupt_vector  out  VECTOR_WIDTH  vector = vector_base + channel id
- interrupt_vector_valid  out  1  one-cycle strobe qualifying interrupt_vector

## Operation

Registers (register_address):
- 0 CONTROL: bit0 auto_eoi; bit1 rotate_on_eoi; bits[15:8] vector_base.
- 1 MASK: 1 = channel masked.
- 2 TRIGGER: 1 = edge, 0 = level.
- 3 EOI, write-only: bit8 = 1 means specific, clearing ISR[bits4:0]; bit8 = 0 means non-specific, clearing the highest-priority set ISR bit.
- 4 IRR, read-only.
- 5 ISR, read-only.
- 6 PRIORITY, read-only: bits[4:0] = lowest-priority channel id.
- Writes to addresses 4–7 are ignored. Reads of 3 and 7 return 0. Bits at or above NUM_IRQ read 0.

IRR behaviour:
- Edge channel: a rising edge (current sample 1, previous 0) sets the IRR bit. The bit clears on acknowledge of that channel.
- Level channel: the IRR bit is the registered pin value.

Priority:
- The highest-priority channel is (lowest_priority + 1) mod NUM_IRQ. Priority descends cyclically from there.
- The winner is the highest-priority channel in IRR & ~MASK whose priority is strictly above every set ISR bit.

State machine:
- IDLE: when a winner exists, go to PENDING and set interrupt_to_cpu = 1.
- PENDING:
  - If the winner vanishes (masked, or level dropped), return to IDLE with interrupt_to_cpu = 0.
  - On interrupt_acknowledge, go to ACK: latch the winner, set its ISR bit (unless auto_eoi), clear its edge IRR bit, and drive the vector.
- ACK: last one cycle, then go to IDLE.

Spurious acknowledge (acknowledge in IDLE, or no winner at the acknowledge cycle):
- Vector = vector_base + (NUM_IRQ-1).
- ISR and IRR are unchanged.

EOI and rotation:
- When rotate_on_eoi is set, a non-specific EOI makes the cleared channel the lowest priority.
- When auto_eoi and rotate_on_eoi are both set, rotation happens at acknowledge.
- A non-specific EOI with ISR = 0 is a no-op.

Simultaneous events:
- Edge and acknowledge-clear on the same channel in the same cycle: the set wins.
- EOI and acknowledge in the same cycle: the EOI is applied first, then the ISR is set.
- A register write and acknowledge in the same cycle: arbitration for that cycle uses the old register values.

## Timing

Reset values:
- MASK = all ones; TRIGGER = all ones; CONTROL = 0.
- IRR = ISR = 0; lowest_priority = NUM_IRQ-1, so channel 0 is highest.
- interrupt_to_cpu = 0; interrupt_vector = 0; interrupt_vector_valid = 0; register_read_data = 0; state IDLE.
- Reset mid-handshake aborts it: no vector strobe is issued.

Latencies:
- Pin edge at cycle t → IRR bit set at t+1 → interrupt_to_cpu high at t+2.
- Acknowledge at cycle a → interrupt_vector_valid high for exactly cycle a+1; interrupt_to_cpu low at a+1; earliest reassertion is a+2.
- A write takes effect at the next cycle.
- register_read_data is valid one cycle after the strobe and holds until the next read.

## Structure
- Package pic_multichannel_pkg holds:
  - register address localparams;
  - CONTROL bit positions;
  - the state enum {IDLE, PENDING, ACK}.
- Sub-module pic_priority_resolver is combinational. It takes request, mask, ISR and lowest_priority, and returns a winner id, a winner-valid flag and the highest in-service id. It is implemented by rotate, find-first, rotate-back.
- The top holds the registers, edge detect, FSM and read mux.

## Test plan
- Reset, unmask channel 3 (MASK = 0xFFF7), pulse IRQ3, acknowledge → vector_valid with vector 0x03; ISR = 0x0008; IRR = 0; interrupt_to_cpu stays low until EOI.
- vector_base = 0x20, IRQ2 and IRQ5 edges in the same cycle, all unmasked → first acknowledge gives 0x22. Non-specific EOI, then second acknowledge gives 0x25. Nesting: IRQ1 during ISR[5] asserts interrupt_to_cpu; IRQ7 does not.
- TRIGGER bit4 = 0, level IRQ4 held, acknowledge, EOI → IRQ4 re-interrupts. Drop the pin while PENDING → interrupt_to_cpu falls. Then acknowledge → spurious vector base + 15 with ISR unchanged.
- rotate_on_eoi = 1: service IRQ0, then non-specific EOI → PRIORITY reads 0. Simultaneous IRQ0 and IRQ1 → IRQ1 wins.
- auto_eoi = 1: acknowledge IRQ6 → ISR stays 0; IRQ6 edge re-serviced without EOI.
- Assert reset_n low in the ACK cycle → no vector_valid; all outputs at reset values.
